// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 matrix keypad scanner.
// Drives one column at a time and synchronizes the row lines. A press
// is debounced, encoded as {col_idx, row_idx}, and offered on a
// valid/ready output register. The scanner then waits for a debounced
// release before it moves on to the next column.
module keypad_scan_ctrl #(
    parameter int SCAN_TICKS     = 216000,
    parameter int DEBOUNCE_TICKS = 270000
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic [3:0] filas_raw,
    output logic [3:0] columnas,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       overrun
);

    localparam int DWELL_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int DEB_W   = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_TICKS - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_TICKS - 1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        EMIT,
        RELEASE
    } state_t;

    state_t             state, state_n;
    logic [3:0]         filas_m, filas_s;
    logic [1:0]         col_idx, col_idx_n;
    logic [DWELL_W-1:0] dwell, dwell_n;
    logic [DEB_W-1:0]   deb, deb_n;
    logic [3:0]         ref_rows, ref_rows_n;
    logic [1:0]         row_idx;
    logic               emit_load;
    logic               emit_drop;

    // Two-flop synchronizer for the asynchronous row lines
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            filas_m <= 4'b0000;
            filas_s <= 4'b0000;
        end else begin
            filas_m <= filas_raw;
            filas_s <= filas_m;
        end
    end

    // FSM state plus the scan/debounce datapath registers
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state    <= SCAN;
            col_idx  <= 2'd0;
            dwell    <= '0;
            deb      <= '0;
            ref_rows <= 4'b0000;
        end else begin
            state    <= state_n;
            col_idx  <= col_idx_n;
            dwell    <= dwell_n;
            deb      <= deb_n;
            ref_rows <= ref_rows_n;
        end
    end

    // Next-state logic; the column and dwell count are only touched in SCAN or at release exit
    always_comb begin
        state_n    = state;
        col_idx_n  = col_idx;
        dwell_n    = dwell;
        deb_n      = deb;
        ref_rows_n = ref_rows;
        emit_load  = 1'b0;
        emit_drop  = 1'b0;
        case (state)
            SCAN: begin
                if (filas_s != 4'b0000) begin
                    ref_rows_n = filas_s;
                    deb_n      = '0;
                    state_n    = DEBOUNCE;
                end else if (dwell == DWELL_LAST) begin
                    dwell_n   = '0;
                    col_idx_n = col_idx + 2'd1;
                end else begin
                    dwell_n = dwell + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (filas_s != ref_rows) begin
                    state_n = SCAN;
                end else if (deb == DEB_LAST) begin
                    deb_n   = '0;
                    state_n = EMIT;
                end else begin
                    deb_n = deb + 1'b1;
                end
            end
            EMIT: begin
                if (!key_valid || key_ready) begin
                    emit_load = 1'b1;
                end else begin
                    emit_drop = 1'b1;
                end
                deb_n   = '0;
                state_n = RELEASE;
            end
            RELEASE: begin
                if (filas_s != 4'b0000) begin
                    deb_n = '0;
                end else if (deb == DEB_LAST) begin
                    deb_n     = '0;
                    dwell_n   = '0;
                    col_idx_n = col_idx + 2'd1;
                    state_n   = SCAN;
                end else begin
                    deb_n = deb + 1'b1;
                end
            end
            default: begin
                state_n = SCAN;
            end
        endcase
    end

    // Highest-priority row: bit3 is row 0, so the topmost pressed row wins
    always_comb begin
        if (ref_rows[3]) begin
            row_idx = 2'd0;
        end else if (ref_rows[2]) begin
            row_idx = 2'd1;
        end else if (ref_rows[1]) begin
            row_idx = 2'd2;
        end else begin
            row_idx = 2'd3;
        end
    end

    // One-hot column drive derived from the column index
    always_comb begin
        columnas = 4'b1000 >> col_idx;
    end

    // Output register: load on emit, drop after a transfer, flag a key lost to a full register
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= emit_drop;
            if (emit_load) begin
                key_code  <= {col_idx, row_idx};
                key_valid <= 1'b1;
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: self-checking bench for keypad_scan_ctrl with short scan/debounce times.
module tb_keypad_scan_ctrl;

    localparam int SCAN_T = 8;
    localparam int DEB_T  = 4;

    logic       clk = 1'b0;
    logic       n_reset;
    logic [3:0] filas_raw;
    logic [3:0] columnas;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       overrun;

    // Keypad stimulus: either direct row drive or a physical key matrix model
    logic       use_pad;
    logic [3:0] raw_direct;
    logic [3:0] pad [4];
    logic [3:0] pad_rows;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard for the randomized section
    logic       mon_en = 1'b0;
    logic [3:0] exp_q [$];
    int         n_xfer = 0;
    int         n_expected = 0;
    logic       prev_hold = 1'b0;
    logic [3:0] prev_code = 4'h0;
    int         stall = 0;

    typedef struct {
        int         col;
        logic [3:0] rows;
        logic [3:0] exp_code;
    } vec_t;

    vec_t vecs [6];

    keypad_scan_ctrl #(
        .SCAN_TICKS    (SCAN_T),
        .DEBOUNCE_TICKS(DEB_T)
    ) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .filas_raw(filas_raw),
        .columnas (columnas),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .overrun  (overrun)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // A pressed key connects its column line to its row line
    always_comb begin
        pad_rows = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            if (columnas[3-c]) pad_rows = pad_rows | pad[c];
        end
    end

    assign filas_raw = use_pad ? pad_rows : raw_direct;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random ready, forced high if the consumer has stalled too long
    task automatic randTick();
        tick();
        if (key_valid && !key_ready) stall++;
        else stall = 0;
        key_ready = (stall >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
    endtask

    // Row index from the keypad rule: topmost pressed row (bit3 = row 0)
    function automatic logic [1:0] rowIndex(input logic [3:0] rows);
        for (int i = 0; i < 4; i++) begin
            if (rows[3-i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    task automatic doReset();
        n_reset    = 1'b0;
        raw_direct = 4'b0000;
        for (int c = 0; c < 4; c++) pad[c] = 4'b0000;
        repeat (2) tick();
        n_reset = 1'b1;
    endtask

    task automatic waitKey(input int limit, output int lat, output logic seen);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < limit) begin
            tick();
            lat++;
            seen = key_valid;
        end
    endtask

    // Apply one table vector: press on a known column, check code, latency and release
    task automatic applyStimulus(input vec_t v);
        int   lat;
        logic seen;
        key_ready = 1'b1;
        use_pad   = 1'b0;
        doReset();
        repeat (8 * v.col + 1) tick();
        checkOutput("table_column", columnas, 4'b1000 >> v.col);
        raw_direct = v.rows;
        waitKey(20, lat, seen);
        checkOutput("table_key_seen", seen, 1);
        checkOutput("table_latency_ok", (lat >= 7 && lat <= 9), 1);
        checkOutput("table_key_code", key_code, v.exp_code);
        tick();
        checkOutput("table_valid_one_cycle", key_valid, 0);
        repeat (10) tick();
        raw_direct = 4'b0000;
        repeat (5) tick();
        checkOutput("table_release_hold", columnas, 4'b1000 >> v.col);
        repeat (3) tick();
        checkOutput("table_release_next", columnas, 4'b1000 >> ((v.col + 1) % 4));
    endtask

    // Per-cycle invariants and the transfer scoreboard
    always @(negedge clk) begin : monitor
        logic [3:0] exp_code;
        checkOutput("columnas_onehot", 32'($onehot(columnas)), 1);
        if (mon_en) begin
            if (prev_hold) checkOutput("key_code_stable", key_code, prev_code);
            checkOutput("overrun_idle", overrun, 0);
            if (key_valid && key_ready) begin
                n_xfer++;
                checkOutput("scoreboard_has_key", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_code = exp_q.pop_front();
                    checkOutput("random_key_code", key_code, exp_code);
                end
            end
            prev_hold = key_valid && !key_ready;
            prev_code = key_code;
        end else begin
            prev_hold = 1'b0;
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   lat;
        int   ovr_count;
        logic seen;

        vecs[0] = '{col: 1, rows: 4'b1000, exp_code: 4'h4};
        vecs[1] = '{col: 0, rows: 4'b0110, exp_code: 4'h1};
        vecs[2] = '{col: 3, rows: 4'b0001, exp_code: 4'hF};
        vecs[3] = '{col: 2, rows: 4'b0011, exp_code: 4'hA};
        vecs[4] = '{col: 0, rows: 4'b1111, exp_code: 4'h0};
        vecs[5] = '{col: 3, rows: 4'b0100, exp_code: 4'hD};

        use_pad    = 1'b0;
        raw_direct = 4'b0000;
        for (int c = 0; c < 4; c++) pad[c] = 4'b0000;
        key_ready  = 1'b1;

        // Asynchronous reset values, checked before any clock edge
        n_reset = 1'b1;
        #2;
        n_reset = 1'b0;
        #1;
        checkOutput("reset_columnas", columnas, 4'b1000);
        checkOutput("reset_key_code", key_code, 0);
        checkOutput("reset_key_valid", key_valid, 0);
        checkOutput("reset_overrun", overrun, 0);

        // Idle rotation after reset
        $display("[TB] idle column rotation");
        doReset();
        checkOutput("idle_col_start", columnas, 4'b1000);
        for (int n = 1; n <= 40; n++) begin
            tick();
            checkOutput("idle_columnas", columnas, 4'b1000 >> ((n / SCAN_T) % 4));
            checkOutput("idle_key_valid", key_valid, 0);
        end

        // Table-driven presses
        $display("[TB] table vectors");
        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        // Bounce on column 3 is rejected and the column resumes its dwell
        $display("[TB] bounce rejection");
        key_ready = 1'b1;
        use_pad   = 1'b0;
        doReset();
        repeat (25) tick();
        checkOutput("bounce_column", columnas, 4'b0001);
        raw_direct = 4'b0010;
        repeat (2) tick();
        raw_direct = 4'b0000;
        for (int n = 28; n <= 40; n++) begin
            tick();
            if (n == 33) checkOutput("bounce_col_held", columnas, 4'b0001);
            if (n == 37) checkOutput("bounce_col_rotated", columnas, 4'b1000);
            checkOutput("bounce_no_key", key_valid, 0);
        end

        // Overrun: second key while the first is still undelivered
        $display("[TB] overrun");
        use_pad   = 1'b1;
        key_ready = 1'b0;
        doReset();
        pad[0] = 4'b1000;
        waitKey(60, lat, seen);
        checkOutput("ovr_first_seen", seen, 1);
        checkOutput("ovr_first_code", key_code, 4'h0);
        pad[0] = 4'b0000;
        repeat (20) tick();
        pad[1] = 4'b0100;
        ovr_count = 0;
        for (int n = 0; n < 80; n++) begin
            tick();
            if (n == 40) pad[1] = 4'b0000;
            if (overrun) ovr_count++;
        end
        checkOutput("ovr_pulse_count", ovr_count, 1);
        checkOutput("ovr_code_kept", key_code, 4'h0);
        checkOutput("ovr_valid_kept", key_valid, 1);
        key_ready = 1'b1;
        tick();
        checkOutput("ovr_after_transfer", key_valid, 0);
        repeat (20) tick();
        checkOutput("ovr_no_second_key", key_valid, 0);

        // Reset during RELEASE with a pending key, then during DEBOUNCE
        $display("[TB] reset mid-operation");
        use_pad   = 1'b0;
        key_ready = 1'b0;
        doReset();
        repeat (17) tick();
        raw_direct = 4'b0001;
        waitKey(20, lat, seen);
        checkOutput("rst_key_seen", seen, 1);
        checkOutput("rst_key_code", key_code, 4'hB);
        repeat (2) tick();
        #2;
        n_reset = 1'b0;
        #1;
        checkOutput("rst_rel_columnas", columnas, 4'b1000);
        checkOutput("rst_rel_key_valid", key_valid, 0);
        checkOutput("rst_rel_key_code", key_code, 0);
        checkOutput("rst_rel_overrun", overrun, 0);
        raw_direct = 4'b0000;
        tick();
        n_reset = 1'b1;
        repeat (17) tick();
        raw_direct = 4'b0001;
        repeat (4) tick();
        #2;
        n_reset = 1'b0;
        #1;
        checkOutput("rst_deb_columnas", columnas, 4'b1000);
        checkOutput("rst_deb_key_valid", key_valid, 0);
        raw_direct = 4'b0000;
        tick();
        n_reset   = 1'b1;
        key_ready = 1'b1;
        seen      = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (key_valid) seen = 1'b1;
        end
        checkOutput("rst_no_spurious_key", seen, 0);

        // Randomized presses on the key matrix model against the scoreboard
        $display("[TB] randomized key presses");
        use_pad   = 1'b1;
        key_ready = 1'b1;
        doReset();
        exp_q.delete();
        stall  = 0;
        mon_en = 1'b1;
        for (int it = 0; it < 16; it++) begin
            int         c;
            logic [3:0] mask;
            c    = $urandom_range(0, 3);
            mask = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 3) == 0) begin
                pad[c] = mask;
                repeat (2) randTick();
                pad[c] = 4'b0000;
                repeat (12) randTick();
            end else begin
                exp_q.push_back({2'(c), rowIndex(mask)});
                n_expected++;
                pad[c] = mask;
                repeat (60) randTick();
                pad[c] = 4'b0000;
                repeat (15) randTick();
            end
        end
        repeat (20) randTick();
        mon_en = 1'b0;
        checkOutput("random_all_delivered", exp_q.size(), 0);
        checkOutput("random_transfer_count", n_xfer, n_expected);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
